// File: rtl/encoder_8_3.sv
// Registered 8-to-3 priority encoder (highest set bit wins) with enable and valid flag.
// Define ENCODER_8_3_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module encoder_8_3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Din,
  input  logic       En,
  output logic [2:0] Eo,
  output logic       Valid
);

  logic [7:0] w_din;
  logic       w_en;
  logic [2:0] w_eo;
  logic       w_valid;
  logic [2:0] r_eo;
  logic       r_valid;

`ifdef ENCODER_8_3_IN_REG_EN
  logic [7:0] r_din;
  logic       r_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din <= 8'h00;
      r_en  <= 1'b0;
    end else begin
      r_din <= Din;
      r_en  <= En;
    end
  end

  assign w_din = r_din;
  assign w_en  = r_en;
`else
  assign w_din = Din;
  assign w_en  = En;
`endif

  // Ascending scan: later (higher) set bits overwrite lower ones, so the highest wins.
  always_comb begin
    w_eo    = 3'd0;
    w_valid = |w_din;
    for (int i = 0; i < 8; i++) begin
      if (w_din[i]) w_eo = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eo    <= 3'd0;
      r_valid <= 1'b0;
    end else if (w_en) begin
      r_eo    <= w_eo;
      r_valid <= w_valid;
    end else begin
      r_eo    <= 3'd0;
      r_valid <= 1'b0;
    end
  end

  assign Eo    = r_eo;
  assign Valid = r_valid;

endmodule

// File: tb/tb_encoder_8_3.sv
// Self-checking bench for encoder_8_3: directed test-plan steps plus random vectors
// checked against an arithmetic reference model (floor(log2(Din))) and a latency queue.
module tb_encoder_8_3;

`ifdef ENCODER_8_3_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] Din;
  logic       En;
  logic [2:0] Eo;
  logic       Valid;

  int n_chk;
  int n_fail;
  logic [3:0] exp_q[$];

  encoder_8_3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Din   (Din),
    .En    (En),
    .Eo    (Eo),
    .Valid (Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {valid, index}; index of highest set bit = clog2(d+1)-1 for d>0.
  function automatic logic [3:0] model(input logic [7:0] d, input logic e);
    int n;
    if (!e || d == 8'h00) return 4'b0000;
    n = $clog2(int'(d) + 1) - 1;
    return {1'b1, 3'(n)};
  endfunction

  task automatic check_out(input string tag, input logic [2:0] e_eo, input logic e_v);
    n_chk++;
    assert (Eo === e_eo) else begin
      n_fail++;
      $error("FAIL %s Eo: observed %0d expected %0d", tag, Eo, e_eo);
    end
    n_chk++;
    assert (Valid === e_v) else begin
      n_fail++;
      $error("FAIL %s Valid: observed %0b expected %0b", tag, Valid, e_v);
    end
  endtask

  task automatic reset_pipe();
    exp_q.delete();
    for (int k = 0; k < LAT - 1; k++) exp_q.push_back(4'b0000);
  endtask

  // Apply one sample, clock it, and check the output that is due after this edge.
  task automatic drive(input string tag, input logic [7:0] d, input logic e);
    logic [3:0] x;
    Din = d;
    En  = e;
    @(posedge clk);
    #1;
    exp_q.push_back(model(d, e));
    x = exp_q.pop_front();
    check_out(tag, x[2:0], x[3]);
  endtask

  initial begin
    logic [7:0] d;
    logic       e;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    Din    = 8'h00;
    En     = 1'b0;
    #12;
    check_out("reset_state", 3'd0, 1'b0);
    rst_n = 1'b1;
    reset_pipe();

    for (int i = 0; i < 8; i++) drive("ascending", 8'(i), 1'b1);
    for (int i = 0; i < 8; i++) drive("onehot", 8'(1 << i), 1'b1);

    drive("multi_ff", 8'hFF, 1'b1);
    drive("multi_81", 8'h81, 1'b1);
    drive("multi_30", 8'h30, 1'b1);
    drive("multi_0a", 8'h0A, 1'b1);

    for (int i = 0; i < LAT + 1; i++) drive("en_low", 8'h40, 1'b0);
    for (int i = 0; i < LAT + 1; i++) drive("en_high", 8'h40, 1'b1);

    // Asynchronous reset mid-cycle with a live request.
    for (int i = 0; i < LAT + 1; i++) drive("pre_reset", 8'h80, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("reset_async", 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_hold", 3'd0, 1'b0);
    #2;
    rst_n = 1'b1;
    reset_pipe();
    for (int i = 0; i < LAT; i++) drive("post_reset", 8'h80, 1'b1);

    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) d = d & 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      e = ($urandom_range(0, 3) != 0);
      drive("random", d, e);
    end
    for (int i = 0; i < LAT; i++) drive("flush", 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
